// File: rtl/execute_pkg.sv
// Shared definitions for the minuteCore execute stage: ALU opcodes,
// branch types, shifter FSM states and a small opcode helper.
package execute_pkg;

    // Width of a shift amount; the serial shifter walks at most 31 steps.
    localparam int SHAMT_W = 5;

    // ALU operation codes as driven by decode; 11..15 fall back to ADD.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLT   = 4'd2,
        ALU_SLTU  = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_OR    = 4'd5,
        ALU_AND   = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    // Control-transfer kinds; 9..15 behave as no branch.
    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BLT  = 4'd3,
        BR_BGE  = 4'd4,
        BR_BLTU = 4'd5,
        BR_BGEU = 4'd6,
        BR_JAL  = 4'd7,
        BR_JALR = 4'd8
    } br_type_e;

    // Serial shifter control states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shift_state_e;

    // True for the three opcodes that may be handed to the serial shifter.
    function automatic logic is_shift_op(input alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/execute_shifter.sv
// Serial one-bit-per-cycle shifter with its step counter. The final step
// is presented combinationally on o_result together with o_done so the
// execute stage can register it on the same edge the FSM returns to idle.
module shifter
    import execute_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  alu_op_e            i_type,
    input  logic [XLEN-1:0]    i_operand,
    input  logic               i_stall,
    output logic               o_busy,
    output logic               o_done,
    output logic [XLEN-1:0]    o_result
);

    shift_state_e       r_state;
    logic [SHAMT_W-1:0] r_count;
    logic [XLEN-1:0]    r_value;
    alu_op_e            r_type;
    logic [XLEN-1:0]    w_next;

    // One-bit shift of the working value in the captured direction.
    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        w_next = r_value;
        case (r_type)
            ALU_SLL: w_next = {r_value[XLEN-2:0], 1'b0};
            ALU_SRL: w_next = {1'b0, r_value[XLEN-1:1]};
            default: w_next = {r_value[XLEN-1], r_value[XLEN-1:1]};
        endcase
    end

    assign o_busy   = (r_state == ST_SHIFT);
    assign o_done   = o_busy && !i_stall && (r_count == SHAMT_W'(1));
    assign o_result = w_next;

    // Load on start, then step once per unstalled cycle until the count expires.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: reset clears the working value too, so an aborted shift leaves no residue.
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_value <= '0;
            r_type  <= ALU_SLL;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    if (i_start && (i_shamt != '0)) begin
                        r_value <= i_operand;
                        r_count <= i_shamt;
                        r_type  <= i_type;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!i_stall) begin
                        r_value <= w_next;
                        r_count <= r_count - SHAMT_W'(1);
                        if (r_count == SHAMT_W'(1)) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/execute.sv
// minuteCore execute stage: ALU, branch resolution, redirect generation and
// the output register towards memory/writeback. Non-zero shifts are handed
// to the serial shifter, which holds fetch/decode through stall_out.
module execute
    import execute_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipeline_in_valid,
    input  logic [XLEN-1:0]   PC_in,
    input  logic [3:0]        alu_op,
    input  logic [3:0]        br_type,
    input  logic              op_b_sel,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [XLEN-1:0]   imm,
    input  logic [REG_AW-1:0] rd_addr_in,
    input  logic              stall,
    output logic              stall_out,
    output logic              flush,
    output logic [XLEN-1:0]   flush_addr,
    output logic              pipeline_out_valid,
    output logic [XLEN-1:0]   PC_out,
    output logic [XLEN-1:0]   result,
    output logic [XLEN-1:0]   store_data,
    output logic [REG_AW-1:0] rd_addr_out
);

    alu_op_e            w_op;
    br_type_e           w_br;
    logic [XLEN-1:0]    w_op_b;
    logic [SHAMT_W-1:0] w_shamt;
    logic [XLEN-1:0]    w_alu;
    logic               w_eq;
    logic               w_lt;
    logic               w_ltu;
    logic               w_taken;
    logic [XLEN-1:0]    w_jalr_sum;
    logic [XLEN-1:0]    w_target;
    logic [XLEN-1:0]    w_wb_value;
    logic               w_accept;
    logic               w_shift_start;
    logic               w_shift_busy;
    logic               w_shift_done;
    logic [XLEN-1:0]    w_shift_result;

    logic               r_valid;
    logic               r_flush;
    logic [XLEN-1:0]    r_flush_addr;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_result;
    logic [XLEN-1:0]    r_store;
    logic [REG_AW-1:0]  r_rd;
    logic [XLEN-1:0]    r_pend_pc;
    logic [XLEN-1:0]    r_pend_store;
    logic [REG_AW-1:0]  r_pend_rd;

    assign w_op    = alu_op_e'(alu_op);
    assign w_br    = br_type_e'(br_type);
    assign w_op_b  = op_b_sel ? imm : rs2_data;
    assign w_shamt = w_op_b[SHAMT_W-1:0];

    // A wrong-path instruction arriving during a redirect is never accepted.
    assign w_accept      = pipeline_in_valid && !stall_out && !r_flush;
    assign w_shift_start = w_accept && is_shift_op(w_op) && (w_shamt != '0);
    assign stall_out     = stall || w_shift_busy;

    // Single-cycle ALU; shift opcodes only land here when the amount is zero.
    always_comb begin
        w_alu = rs1_data + w_op_b;
        case (w_op)
            ALU_SUB:   w_alu = rs1_data - w_op_b;
            ALU_SLT:   w_alu = XLEN'($signed(rs1_data) < $signed(w_op_b));
            ALU_SLTU:  w_alu = XLEN'(rs1_data < w_op_b);
            ALU_XOR:   w_alu = rs1_data ^ w_op_b;
            ALU_OR:    w_alu = rs1_data | w_op_b;
            ALU_AND:   w_alu = rs1_data & w_op_b;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:   w_alu = rs1_data;
            ALU_PASSB: w_alu = w_op_b;
            default:   w_alu = rs1_data + w_op_b;
        endcase
    end

    // Branch conditions always compare the two register operands.
    assign w_eq  = (rs1_data == rs2_data);
    assign w_lt  = ($signed(rs1_data) < $signed(rs2_data));
    assign w_ltu = (rs1_data < rs2_data);

    // Resolve whether the control transfer is taken.
    always_comb begin
        w_taken = 1'b0;
        case (w_br)
            BR_BEQ:  w_taken = w_eq;
            BR_BNE:  w_taken = !w_eq;
            BR_BLT:  w_taken = w_lt;
            BR_BGE:  w_taken = !w_lt;
            BR_BLTU: w_taken = w_ltu;
            BR_BGEU: w_taken = !w_ltu;
            BR_JAL,
            BR_JALR: w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_jalr_sum = rs1_data + imm;
    assign w_target   = (w_br == BR_JALR) ? {w_jalr_sum[XLEN-1:1], 1'b0} : (PC_in + imm);
    assign w_wb_value = ((w_br == BR_JAL) || (w_br == BR_JALR)) ? (PC_in + XLEN'(4)) : w_alu;

    shifter #(
        .XLEN (XLEN)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_shift_start),
        .i_shamt   (w_shamt),
        .i_type    (w_op),
        .i_operand (rs1_data),
        .i_stall   (stall),
        .o_busy    (w_shift_busy),
        .o_done    (w_shift_done),
        .o_result  (w_shift_result)
    );

    // Capture the side-band fields of a shift so completion does not rely on decode holding them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_pc    <= '0;
            r_pend_store <= '0;
            r_pend_rd    <= '0;
        end else if (w_shift_start) begin
            r_pend_pc    <= PC_in;
            r_pend_store <= rs2_data;
            r_pend_rd    <= rd_addr_in;
        end
    end

    // Output register: holds on stall, otherwise loads a new or completing instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_flush      <= 1'b0;
            r_flush_addr <= '0;
            r_pc         <= '0;
            r_result     <= '0;
            r_store      <= '0;
            r_rd         <= '0;
        end else if (!stall) begin
            r_valid      <= 1'b0;
            r_flush      <= 1'b0;
            r_flush_addr <= '0;
            if (w_accept && !w_shift_start) begin
                r_valid      <= 1'b1;
                r_pc         <= PC_in;
                r_result     <= w_wb_value;
                r_store      <= rs2_data;
                r_rd         <= rd_addr_in;
                r_flush      <= w_taken;
                r_flush_addr <= w_taken ? w_target : '0;
            end else if (w_shift_done) begin
                r_valid  <= 1'b1;
                r_pc     <= r_pend_pc;
                r_result <= w_shift_result;
                r_store  <= r_pend_store;
                r_rd     <= r_pend_rd;
            end
        end
    end

    assign pipeline_out_valid = r_valid;
    assign flush              = r_flush;
    assign flush_addr         = r_flush_addr;
    assign PC_out             = r_pc;
    assign result             = r_result;
    assign store_data         = r_store;
    assign rd_addr_out        = r_rd;

endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage: a table of single-cycle vectors
// followed by hand sequences for shifts, stalls, flush discard and reset.
module tb_execute;

    logic        clk;
    logic        reset;
    logic        pipeline_in_valid;
    logic [31:0] PC_in;
    logic [3:0]  alu_op;
    logic [3:0]  br_type;
    logic        op_b_sel;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd_addr_in;
    logic        stall;
    logic        stall_out;
    logic        flush;
    logic [31:0] flush_addr;
    logic        pipeline_out_valid;
    logic [31:0] PC_out;
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  rd_addr_out;

    int n_vec;
    int n_err;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  br;
        logic        bsel;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [31:0] exp_res;
        logic        exp_flush;
        logic [31:0] exp_faddr;
    } vec_t;

    vec_t vq[$];

    execute #(
        .XLEN   (32),
        .REG_AW (5)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .pipeline_in_valid  (pipeline_in_valid),
        .PC_in              (PC_in),
        .alu_op             (alu_op),
        .br_type            (br_type),
        .op_b_sel           (op_b_sel),
        .rs1_data           (rs1_data),
        .rs2_data           (rs2_data),
        .imm                (imm),
        .rd_addr_in         (rd_addr_in),
        .stall              (stall),
        .stall_out          (stall_out),
        .flush              (flush),
        .flush_addr         (flush_addr),
        .pipeline_out_valid (pipeline_out_valid),
        .PC_out             (PC_out),
        .result             (result),
        .store_data         (store_data),
        .rd_addr_out        (rd_addr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [3:0] br, input logic bsel,
                                input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] im, input logic [4:0] rd, input logic [31:0] res,
                                input logic fl, input logic [31:0] fa);
        vec_t v;
        v.op = op; v.br = br; v.bsel = bsel; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = im; v.rd = rd; v.exp_res = res; v.exp_flush = fl; v.exp_faddr = fa;
        return v;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [3:0] br, input logic bsel,
                         input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] im, input logic [4:0] rd);
        alu_op = op; br_type = br; op_b_sel = bsel; PC_in = pc;
        rs1_data = rs1; rs2_data = rs2; imm = im; rd_addr_in = rd;
    endtask

    // Shift with optional mid-shift stall window; checks latency and stall_out length.
    task automatic run_shift(input string name, input logic [3:0] op, input logic [31:0] rs1,
                             input logic [31:0] amt, input logic [4:0] rd, input logic [31:0] pc,
                             input logic [31:0] exp_res, input int st_from, input int st_len,
                             input int exp_lat, input int exp_stalls);
        int lat;
        int stalls;
        drive(op, 4'd0, 1'b1, pc, rs1, 32'h0000_5A5A, amt, rd);
        pipeline_in_valid = 1'b1;
        tick();
        lat = -1;
        stalls = 0;
        for (int c = 1; c <= 60; c++) begin
            stall = (c >= st_from) && (c < st_from + st_len);
            #1;
            if (stall_out) stalls++;
            else pipeline_in_valid = 1'b0;
            if (pipeline_out_valid) begin
                lat = c;
                break;
            end
            tick();
        end
        stall = 1'b0;
        pipeline_in_valid = 1'b0;
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " stall_out cycles"}, 32'(stalls), 32'(exp_stalls));
        check({name, " result"}, result, exp_res);
        check({name, " rd"}, 32'(rd_addr_out), 32'(rd));
        check({name, " PC_out"}, PC_out, pc);
        check({name, " store_data"}, store_data, 32'h0000_5A5A);
        tick();
        check({name, " valid one cycle"}, 32'(pipeline_out_valid), 32'd0);
    endtask

    initial begin
        int cnt;
        vec_t v;
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        stall = 1'b0;
        pipeline_in_valid = 1'b0;
        drive(4'd0, 4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);

        // op, br, bsel, pc, rs1, rs2, imm, rd, exp result, exp flush, exp flush_addr
        vq.push_back(mk(4'd0,  4'd0, 1'b1, 32'h0000_0010, 32'd5,         32'h55,        32'd7,         5'd1, 32'd12,        1'b0, 32'h0));
        vq.push_back(mk(4'd1,  4'd0, 1'b0, 32'h0000_0014, 32'd0,         32'd1,         32'd0,         5'd2, 32'hFFFF_FFFF, 1'b0, 32'h0));
        vq.push_back(mk(4'd2,  4'd0, 1'b0, 32'h0000_0018, 32'hFFFF_FFFF, 32'd1,         32'd0,         5'd3, 32'd1,         1'b0, 32'h0));
        vq.push_back(mk(4'd3,  4'd0, 1'b0, 32'h0000_001C, 32'hFFFF_FFFF, 32'd1,         32'd0,         5'd4, 32'd0,         1'b0, 32'h0));
        vq.push_back(mk(4'd4,  4'd0, 1'b0, 32'h0000_0020, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0,         5'd5, 32'h0000_FF00, 1'b0, 32'h0));
        vq.push_back(mk(4'd5,  4'd0, 1'b1, 32'h0000_0024, 32'h0000_F000, 32'd0,         32'h0000_000F, 5'd6, 32'h0000_F00F, 1'b0, 32'h0));
        vq.push_back(mk(4'd6,  4'd0, 1'b0, 32'h0000_0028, 32'h0000_FF00, 32'h0000_0FF0, 32'd0,         5'd7, 32'h0000_0F00, 1'b0, 32'h0));
        vq.push_back(mk(4'd10, 4'd0, 1'b1, 32'h0000_002C, 32'hDEAD_BEEF, 32'd3,         32'h0000_1234, 5'd8, 32'h0000_1234, 1'b0, 32'h0));
        vq.push_back(mk(4'd12, 4'd0, 1'b0, 32'h0000_0030, 32'd3,         32'd4,         32'd0,         5'd9, 32'd7,         1'b0, 32'h0));
        vq.push_back(mk(4'd7,  4'd0, 1'b0, 32'h0000_0034, 32'h0000_ABCD, 32'h0000_0020, 32'd0,         5'd10, 32'h0000_ABCD, 1'b0, 32'h0));
        vq.push_back(mk(4'd0,  4'd0, 1'b1, 32'h0000_0038, 32'hFFFF_FFFF, 32'd0,         32'd2,         5'd11, 32'd1,         1'b0, 32'h0));
        vq.push_back(mk(4'd0,  4'd1, 1'b0, 32'h0000_0100, 32'd9,         32'd9,         32'h20,        5'd0, 32'd18,        1'b1, 32'h0000_0120));
        vq.push_back(mk(4'd0,  4'd1, 1'b0, 32'h0000_0100, 32'd9,         32'd8,         32'h20,        5'd0, 32'd17,        1'b0, 32'h0));
        vq.push_back(mk(4'd0,  4'd8, 1'b1, 32'h0000_0040, 32'h0000_0203, 32'd0,         32'd1,         5'd1, 32'h0000_0044, 1'b1, 32'h0000_0204));
        vq.push_back(mk(4'd0,  4'd7, 1'b1, 32'h0000_0200, 32'd0,         32'd0,         32'hFFFF_FFF8, 5'd1, 32'h0000_0204, 1'b1, 32'h0000_01F8));
        vq.push_back(mk(4'd1,  4'd3, 1'b0, 32'h0000_0300, 32'hFFFF_FFFF, 32'd1,         32'h10,        5'd0, 32'hFFFF_FFFE, 1'b1, 32'h0000_0310));
        vq.push_back(mk(4'd1,  4'd5, 1'b0, 32'h0000_0300, 32'hFFFF_FFFF, 32'd1,         32'h10,        5'd0, 32'hFFFF_FFFE, 1'b0, 32'h0));
        vq.push_back(mk(4'd0,  4'd4, 1'b1, 32'h0000_0010, 32'd5,         32'd5,         32'd4,         5'd0, 32'd9,         1'b1, 32'h0000_0014));
        vq.push_back(mk(4'd0,  4'd6, 1'b0, 32'h0000_0010, 32'd1,         32'hFFFF_FFFF, 32'd4,         5'd0, 32'd0,         1'b0, 32'h0));
        vq.push_back(mk(4'd0,  4'd2, 1'b0, 32'h0000_0080, 32'd3,         32'd4,         32'hFFFF_FFF0, 5'd0, 32'd7,         1'b1, 32'h0000_0070));

        // Reset state
        #1 reset = 1'b1;
        #2;
        check("reset valid", 32'(pipeline_out_valid), 32'd0);
        check("reset flush", 32'(flush), 32'd0);
        check("reset flush_addr", flush_addr, 32'd0);
        check("reset result", result, 32'd0);
        check("reset PC_out", PC_out, 32'd0);
        check("reset rd", 32'(rd_addr_out), 32'd0);
        check("reset stall_out", 32'(stall_out), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        // Table of single-cycle instructions
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            drive(v.op, v.br, v.bsel, v.pc, v.rs1, v.rs2, v.imm, v.rd);
            pipeline_in_valid = 1'b1;
            tick();
            pipeline_in_valid = 1'b0;
            check($sformatf("vec%0d valid", i), 32'(pipeline_out_valid), 32'd1);
            check($sformatf("vec%0d result", i), result, v.exp_res);
            check($sformatf("vec%0d rd", i), 32'(rd_addr_out), 32'(v.rd));
            check($sformatf("vec%0d PC_out", i), PC_out, v.pc);
            check($sformatf("vec%0d store_data", i), store_data, v.rs2);
            check($sformatf("vec%0d stall_out", i), 32'(stall_out), 32'd0);
            check($sformatf("vec%0d flush", i), 32'(flush), 32'(v.exp_flush));
            if (v.exp_flush) check($sformatf("vec%0d flush_addr", i), flush_addr, v.exp_faddr);
            tick();
            check($sformatf("vec%0d valid drop", i), 32'(pipeline_out_valid), 32'd0);
            check($sformatf("vec%0d flush drop", i), 32'(flush), 32'd0);
        end

        // Serial shifts, including a mid-shift downstream stall and the max amount
        run_shift("sra4", 4'd9, 32'h8000_0000, 32'd4, 5'd7, 32'h0000_0500, 32'hF800_0000, 99, 0, 5, 4);
        run_shift("sra4 stalled", 4'd9, 32'h8000_0000, 32'd4, 5'd7, 32'h0000_0504, 32'hF800_0000, 2, 2, 7, 6);
        run_shift("sll5", 4'd7, 32'h0000_0003, 32'd5, 5'd12, 32'h0000_0508, 32'h0000_0060, 99, 0, 6, 5);
        run_shift("srl31", 4'd8, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0000_050C, 32'h0000_0001, 99, 0, 32, 31);

        // Output register holds while downstream stalls
        drive(4'd0, 4'd0, 1'b0, 32'h0000_0700, 32'd10, 32'd20, 32'd0, 5'd4);
        pipeline_in_valid = 1'b1;
        tick();
        pipeline_in_valid = 1'b0;
        stall = 1'b1;
        tick();
        check("hold valid", 32'(pipeline_out_valid), 32'd1);
        check("hold result", result, 32'd30);
        check("hold stall_out", 32'(stall_out), 32'd1);
        stall = 1'b0;
        tick();
        check("hold release", 32'(pipeline_out_valid), 32'd0);

        // Wrong-path instruction during flush is discarded
        drive(4'd0, 4'd1, 1'b0, 32'h0000_0100, 32'd5, 32'd5, 32'h20, 5'd0);
        pipeline_in_valid = 1'b1;
        tick();
        check("beq flush", 32'(flush), 32'd1);
        check("beq flush_addr", flush_addr, 32'h0000_0120);
        drive(4'd0, 4'd0, 1'b1, 32'h0000_0104, 32'd1, 32'd0, 32'd1, 5'd3);
        tick();
        check("wrong-path valid", 32'(pipeline_out_valid), 32'd0);
        check("flush one cycle", 32'(flush), 32'd0);
        pipeline_in_valid = 1'b0;
        tick();
        check("wrong-path never out", 32'(pipeline_out_valid), 32'd0);

        // Reset in the 2nd cycle of a shift by 8
        drive(4'd7, 4'd0, 1'b1, 32'h0000_0600, 32'd1, 32'h0000_0077, 32'd8, 5'd9);
        pipeline_in_valid = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        pipeline_in_valid = 1'b0;
        #1;
        check("abort valid", 32'(pipeline_out_valid), 32'd0);
        check("abort result", result, 32'd0);
        check("abort store_data", store_data, 32'd0);
        check("abort PC_out", PC_out, 32'd0);
        check("abort stall_out", 32'(stall_out), 32'd0);
        @(negedge clk) reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (pipeline_out_valid) cnt++;
        end
        check("abort no result", 32'(cnt), 32'd0);
        check("abort stall_out after", 32'(stall_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/execute.md
# execute

Execute stage of the minuteCore in-order pipeline, directly downstream of decode. It takes the decoded instruction with its operands, computes ALU results and resolves branches and jumps. It forwards a registered result to the memory/writeback stage and redirects fetch and decode with `flush`/`flush_addr` on every taken control transfer, because fetch always predicts not-taken. Shifts run on a serial shifter that holds the upstream pipeline while it works.

## Interface
Parameters
- `XLEN`, 32: data and address width.
- `REG_AW`, 5: register address width.

Ports
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `pipeline_in_valid`  in  1  decode holds a valid instruction.
- `PC_in`  in  XLEN  PC of that instruction.
- `alu_op`  in  4  ADD=0, SUB=1, SLT=2, SLTU=3, XOR=4, OR=5, AND=6, SLL=7, SRL=8, SRA=9, PASSB=10; 11–15 behave as ADD.
- `br_type`  in  4  NONE=0, BEQ=1, BNE=2, BLT=3, BGE=4, BLTU=5, BGEU=6, JAL=7, JALR=8.
- `op_b_sel`  in  1  1: operand B = `imm`; 0: operand B = `rs2_data`.
- `rs1_data`, `rs2_data`, `imm`  in  XLEN  operands; `imm` is already sign-extended.
- `rd_addr_in`  in  REG_AW  destination register.
- `stall`  in  1  downstream stall.
- `stall_out`  out  1  hold request to fetch and decode.
- `flush`  out  1  one-cycle redirect pulse.
- `flush_addr`  out  XLEN  redirect target.
- `pipeline_out_valid`  out  1  the output register is valid.
- `PC_out`  out  XLEN  PC of the output instruction.
- `result`  out  XLEN  ALU result, or PC+4 for JAL and JALR.
- `store_data`  out  XLEN  `rs2_data` passed through.
- `rd_addr_out`  out  REG_AW  destination register.

## Operation
- An instruction is accepted when `pipeline_in_valid & ~stall_out & ~flush`.
- Operand A is `rs1_data`. Operand B is selected by `op_b_sel`.
- All arithmetic is modulo 2^XLEN, with no overflow flag.
- SLT compares signed and SLTU compares unsigned; each returns 0 or 1.
- Branch comparisons always use `rs1_data` against `rs2_data`, whatever `op_b_sel` is.
- A taken branch targets PC_in+imm. JAL targets PC_in+imm. JALR targets (rs1_data+imm) with bit 0 cleared.
- A branch passes downstream with `rd_addr_out` as decode supplied it. Decode drives 0 for branches.
- FSM states:
  - IDLE: on accepting SLL, SRL or SRA with shamt = B[4:0] ≠ 0, load the shifter and the counter with shamt, then go to SHIFT. Any other accepted op is registered directly.
  - SHIFT: each cycle with `stall`=0, shift one bit and decrement the counter. When the counter reaches 0, register the result and return to IDLE. While `stall`=1, hold the state.
- A shift with shamt=0 completes like an ordinary op.
- `stall_out` = `stall | (state==SHIFT)`, combinational.
- Flush: on accepting a taken branch, JAL or JALR, register `flush`=1 and `flush_addr`=target for exactly one cycle. Any input presented while `flush`=1 is wrong-path and is discarded.
- `stall` is never asserted in the same cycle as `flush`, so a flush is never lost.

## Timing
- Reset (asynchronous): state IDLE, counter 0, and every output 0, including `flush`, `flush_addr`, `PC_out`, `result` and `rd_addr_out`.
- Non-shift ops: the result is valid 1 cycle after acceptance.
- Shift ops: the result is valid shamt+1 cycles after acceptance, with `stall_out` high for shamt cycles.
- `flush` rises in the cycle after acceptance, together with that instruction's `pipeline_out_valid`.
- When `stall`=1, all output registers hold and `pipeline_out_valid` keeps its value.
- When not stalled and no instruction is accepted or completing, `pipeline_out_valid` drops to 0.
- Reset during SHIFT aborts the shift and nothing is emitted.

## Structure
- Put the ALU_OP_*, BR_* and XLEN defines in `def_params.v`, shared with decode.
- Put the serial shift datapath and its counter in a single sub-module, `shifter`, with ports start, shamt, type, operand, stall, busy, done and result.
- Keep the ALU, branch comparison and the output register in `execute`.

## Test plan
- ADD with rs1=5, imm=7, op_b_sel=1: `result`=12 one cycle later, `pipeline_out_valid` high for 1 cycle, `stall_out` never high.
- SUB with 0−1: `result`=0xFFFFFFFF. SLT of 0xFFFFFFFF vs 1 gives 1; SLTU of the same gives 0.
- SRA of 0x80000000 by 4: `stall_out` high for 4 cycles, then `result`=0xF8000000 at cycle 5. Asserting `stall` for 2 cycles mid-shift extends completion to cycle 7.
- BEQ at PC 0x100 with imm 0x20 and rs1=rs2: `flush`=1 for one cycle with `flush_addr`=0x120, and the instruction presented during that cycle never appears at the output. The same test with rs1≠rs2 gives no flush.
- JALR at PC 0x40 with rs1=0x203 and imm=1: `flush_addr`=0x204 and `result`=0x44.
- Assert `reset` at the 2nd cycle of a shift by 8: outputs go to 0 immediately, `stall_out`=0, and no result appears after reset is released.
